test_status_monitor: RTL and testbench

- Synthesizable, multi-channel successor to the simulation-only pass/fail/timeout check performed on the tohost CSR.
- Watches up to NUM_CH CSR write streams (one per core/hart) and decides PASS, FAIL or TIMEOUT.
- Records the failing channel, the failing test number and the elapsed cycle count.
- Sits beside the CPU(s) in the FPGA top and in benches, so ISA tests can be judged in hardware and exposed on LEDs/UART.

---
 rtl/test_status_monitor.sv | 164 ++++++++++++++++
 tb/tb_test_status_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/test_status_monitor.sv
// test_status_monitor
//   Watches NUM_CH tohost-style CSR write streams (one per core/hart) and
//   judges a test run as PASS, FAIL or TIMEOUT. It also records which channel
//   failed, that channel's test number, and the number of RUN cycles elapsed.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   rst          in   asynchronous reset, active low
//   start        in   begin a run (honoured in IDLE only)
//   clear        in   return to IDLE from any state (highest priority)
//   csr_wr_en    in   [NUM_CH] per-channel CSR write strobe
//   csr_wr_data  in   [NUM_CH*CSR_WIDTH] per-channel write data;
//                     bit 0 = done flag, bits [CSR_WIDTH-1:1] = test code
//   busy         out  state is RUN
//   done         out  state is PASS, FAIL or TIMEOUT
//   pass/fail/timeout out  one-hot decode of the terminal state
//   ch_done      out  [NUM_CH] channels that reported a zero code this run
//   fail_ch      out  index of the failing channel
//   fail_code    out  failing test number
//   cycle_count  out  RUN edges elapsed; frozen once a verdict is reached
module test_status_monitor #(
  parameter int NUM_CH         = 1,
  parameter int CSR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CYC_WIDTH      = 32,
  localparam int CH_W          = $clog2(NUM_CH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  input  logic [NUM_CH-1:0]           csr_wr_en,
  input  logic [NUM_CH*CSR_WIDTH-1:0] csr_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [NUM_CH-1:0]           ch_done,
  output logic [CH_W-1:0]             fail_ch,
  output logic [CSR_WIDTH-2:0]        fail_code,
  output logic [CYC_WIDTH-1:0]        cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CH-1:0]    ch_done_q, ch_done_d;
  logic [CH_W-1:0]      fail_ch_q, fail_ch_d;
  logic [CSR_WIDTH-2:0] fail_code_q, fail_code_d;
  logic [CYC_WIDTH-1:0] cycle_q, cycle_d;

  // Per-channel decode of this cycle's writes.
  logic [CSR_WIDTH-2:0] code_w [NUM_CH];
  logic [NUM_CH-1:0]    cmpl_w;       // completion from a channel not yet done
  logic [NUM_CH-1:0]    zero_cmpl_w;  // ... reporting success
  logic [NUM_CH-1:0]    fail_cmpl_w;  // ... reporting a failing test number

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign code_w[gi]      = csr_wr_data[gi*CSR_WIDTH+1 +: CSR_WIDTH-1];
      // Channels already marked done are sticky: any later write, even a
      // nonzero code, is ignored for the rest of the run.
      assign cmpl_w[gi]      = csr_wr_en[gi] & csr_wr_data[gi*CSR_WIDTH] & ~ch_done_q[gi];
      assign zero_cmpl_w[gi] = cmpl_w[gi] & (code_w[gi] == '0);
      assign fail_cmpl_w[gi] = cmpl_w[gi] & (code_w[gi] != '0);
    end
  endgenerate

  // Lowest-index failing channel wins: scan downward so the last hit is
  // the smallest index.
  logic [CH_W-1:0]      fail_idx;
  logic [CSR_WIDTH-2:0] fail_val;
  always_comb begin
    fail_idx = '0;
    fail_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_cmpl_w[i]) begin
        fail_idx = CH_W'(i);
        fail_val = code_w[i];
      end
    end
  end

  logic [CYC_WIDTH-1:0] cyc_inc;
  logic                 timeout_hit;
  assign cyc_inc     = cycle_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_inc == CYC_WIDTH'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    ch_done_d   = ch_done_q;
    fail_ch_d   = fail_ch_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cycle_d   = '0;
          ch_done_d = '0;
        end
      end
      S_RUN: begin
        cycle_d   = cyc_inc;
        ch_done_d = ch_done_q | zero_cmpl_w;
        // Priority on the deciding edge: FAIL, then PASS, then TIMEOUT.
        if (|fail_cmpl_w) begin
          state_d     = S_FAIL;
          fail_ch_d   = fail_idx;
          fail_code_d = fail_val;
        end else if (&(ch_done_q | zero_cmpl_w)) begin
          state_d = S_PASS;
        end else if (timeout_hit) begin
          state_d = S_TIMEOUT;
        end
      end
      default: ;  // terminal states hold until clear or reset
    endcase

    if (clear) begin
      state_d     = S_IDLE;
      ch_done_d   = '0;
      fail_ch_d   = '0;
      fail_code_d = '0;
      cycle_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ch_done_q   <= '0;
      fail_ch_q   <= '0;
      fail_code_q <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_done_q   <= ch_done_d;
      fail_ch_q   <= fail_ch_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign timeout     = (state_q == S_TIMEOUT);
  assign done        = pass | fail | timeout;
  assign ch_done     = ch_done_q;
  assign fail_ch     = fail_ch_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Single-channel instance
  logic        start1 = 1'b0, clear1 = 1'b0;
  logic [0:0]  wr_en1 = '0;
  logic [31:0] wr_data1 = '0;
  logic        busy1, done1, pass1, fail1, timeout1;
  logic [0:0]  ch_done1;
  logic [0:0]  fail_ch1;
  logic [30:0] fail_code1;
  logic [31:0] cyc1;

  // Four-channel instance
  logic         start4 = 1'b0, clear4 = 1'b0;
  logic [3:0]   wr_en4 = '0;
  logic [127:0] wr_data4 = '0;
  logic         busy4, done4, pass4, fail4, timeout4;
  logic [3:0]   ch_done4;
  logic [2:0]   fail_ch4;
  logic [30:0]  fail_code4;
  logic [31:0]  cyc4;

  test_status_monitor #(.NUM_CH(1), .CSR_WIDTH(32), .TIMEOUT_CYCLES(1000), .CYC_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .clear(clear1),
    .csr_wr_en(wr_en1), .csr_wr_data(wr_data1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout(timeout1),
    .ch_done(ch_done1), .fail_ch(fail_ch1), .fail_code(fail_code1), .cycle_count(cyc1)
  );

  test_status_monitor #(.NUM_CH(4), .CSR_WIDTH(32), .TIMEOUT_CYCLES(1000), .CYC_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .clear(clear4),
    .csr_wr_en(wr_en4), .csr_wr_data(wr_data4),
    .busy(busy4), .done(done4), .pass(pass4), .fail(fail4), .timeout(timeout4),
    .ch_done(ch_done4), .fail_ch(fail_ch4), .fail_code(fail_code4), .cycle_count(cyc4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Packed flags {busy,done,pass,fail,timeout}
  function automatic logic [4:0] flags1();
    return {busy1, done1, pass1, fail1, timeout1};
  endfunction
  function automatic logic [4:0] flags4();
    return {busy4, done4, pass4, fail4, timeout4};
  endfunction

  initial begin
    // ---------------- Reset state
    #12;
    check("rst_flags1", 64'(flags1()), 64'b00000);
    check("rst_cyc1", 64'(cyc1), 64'd0);
    check("rst_flags4", 64'(flags4()), 64'b00000);
    rst = 1'b1;
    tick();

    // ---------------- 1-ch PASS after 10 idle RUN edges
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("run_flags", 64'(flags1()), 64'b10000);
    check("run_cyc0", 64'(cyc1), 64'd0);
    ticks(10);
    check("run_cyc10", 64'(cyc1), 64'd10);
    wr_en1 = 1'b1; wr_data1 = 32'h1; tick(); wr_en1 = 1'b0; wr_data1 = '0;
    check("pass_flags", 64'(flags1()), 64'b01100);
    check("pass_cyc", 64'(cyc1), 64'd11);
    check("pass_chdone", 64'(ch_done1), 64'd1);
    ticks(3);
    check("pass_frozen", 64'(cyc1), 64'd11);

    // ---------------- clear in PASS, restart from 0
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    check("clr_flags", 64'(flags1()), 64'b00000);
    check("clr_cyc", 64'(cyc1), 64'd0);
    check("clr_chdone", 64'(ch_done1), 64'd0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("restart_cyc", 64'(cyc1), 64'd0);
    ticks(3);
    check("restart_cyc3", 64'(cyc1), 64'd3);

    // ---------------- bit-0-clear writes are ignored
    wr_en1 = 1'b1; wr_data1 = 32'h0; tick();
    wr_data1 = 32'h6; tick(); wr_en1 = 1'b0; wr_data1 = '0;
    check("nodone_flags", 64'(flags1()), 64'b10000);
    check("nodone_cyc", 64'(cyc1), 64'd5);

    // ---------------- async reset mid-RUN
    @(posedge clk); #2;
    rst = 1'b0; #1;
    check("arst_flags", 64'(flags1()), 64'b00000);
    check("arst_cyc", 64'(cyc1), 64'd0);
    #3; rst = 1'b1;
    tick();

    // ---------------- 1-ch FAIL with code 3, later pass write ignored
    start1 = 1'b1; tick(); start1 = 1'b0;
    wr_en1 = 1'b1; wr_data1 = 32'h7; tick();
    check("fail_flags", 64'(flags1()), 64'b01010);
    check("fail_ch", 64'(fail_ch1), 64'd0);
    check("fail_code", 64'(fail_code1), 64'd3);
    check("fail_cyc", 64'(cyc1), 64'd1);
    wr_data1 = 32'h1; tick(); wr_en1 = 1'b0; wr_data1 = '0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("fail_hold", 64'(flags1()), 64'b01010);
    check("fail_hold_code", 64'(fail_code1), 64'd3);
    check("fail_hold_cyc", 64'(cyc1), 64'd1);
    clear1 = 1'b1; tick(); clear1 = 1'b0;
    check("fail_clr_code", 64'(fail_code1), 64'd0);

    // ---------------- 1-ch TIMEOUT at 1000th edge
    start1 = 1'b1; tick(); start1 = 1'b0;
    ticks(999);
    check("to_pre_flags", 64'(flags1()), 64'b10000);
    check("to_pre_cyc", 64'(cyc1), 64'd999);
    tick();
    check("to_flags", 64'(flags1()), 64'b01001);
    check("to_cyc", 64'(cyc1), 64'd1000);
    clear1 = 1'b1; tick(); clear1 = 1'b0;

    // ---------------- pass on the 1000th edge beats timeout
    start1 = 1'b1; tick(); start1 = 1'b0;
    ticks(999);
    wr_en1 = 1'b1; wr_data1 = 32'h1; tick(); wr_en1 = 1'b0; wr_data1 = '0;
    check("lastedge_flags", 64'(flags1()), 64'b01100);
    check("lastedge_cyc", 64'(cyc1), 64'd1000);
    clear1 = 1'b1; tick(); clear1 = 1'b0;

    // ---------------- 4-ch: ch0,ch2 pass; then ch1 pass + ch3 code 5
    start4 = 1'b1; tick(); start4 = 1'b0;
    wr_en4 = 4'b0101; wr_data4 = {32'h0, 32'h1, 32'h0, 32'h1}; tick();
    check("m_chdone", 64'(ch_done4), 64'b0101);
    check("m_flags", 64'(flags4()), 64'b10000);
    wr_en4 = 4'b1010; wr_data4 = {32'hB, 32'h0, 32'h1, 32'h0}; tick();
    wr_en4 = '0; wr_data4 = '0;
    check("m_fail_flags", 64'(flags4()), 64'b01010);
    check("m_fail_ch", 64'(fail_ch4), 64'd3);
    check("m_fail_code", 64'(fail_code4), 64'd5);
    clear4 = 1'b1; tick(); clear4 = 1'b0;

    // ---------------- 4-ch: ch1 and ch3 fail together, lowest wins
    start4 = 1'b1; tick(); start4 = 1'b0;
    wr_en4 = 4'b1010; wr_data4 = {32'hB, 32'h0, 32'h3, 32'h0}; tick();
    wr_en4 = '0; wr_data4 = '0;
    check("m2_flags", 64'(flags4()), 64'b01010);
    check("m2_fail_ch", 64'(fail_ch4), 64'd1);
    check("m2_fail_code", 64'(fail_code4), 64'd1);
    clear4 = 1'b1; tick(); clear4 = 1'b0;

    // ---------------- 4-ch: all pass on one edge; repeat from done ch ignored
    start4 = 1'b1; tick(); start4 = 1'b0;
    wr_en4 = 4'b0001; wr_data4 = {96'h0, 32'h1}; tick();
    wr_en4 = 4'b1111; wr_data4 = {32'h1, 32'h1, 32'h1, 32'h5}; tick();
    wr_en4 = '0; wr_data4 = '0;
    check("m3_flags", 64'(flags4()), 64'b01100);
    check("m3_chdone", 64'(ch_done4), 64'b1111);
    check("m3_cyc", 64'(cyc4), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
